// File: rtl/usrt_pkg.sv
// Shared USRT definitions: APB front-end state encodings, register slot
// indices and the default access masks of the STATUS/TX/RX register file.
package usrt_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam int REG_STATUS  = 0;
   localparam int REG_TX      = 1;
   localparam int REG_RX      = 2;
   localparam int USRT_N_REGS = 3;

   // STATUS and RX are read-only, TX is write-only.
   localparam logic [USRT_N_REGS-1:0] DEFAULT_WR_MASK = 3'b010;
   localparam logic [USRT_N_REGS-1:0] DEFAULT_RD_MASK = 3'b101;

endpackage

// File: rtl/apb_reg_port_if.sv
// APB3 bus bundle between the interconnect (master) and the USRT register
// front-end (slave).
interface apb_reg_port_if
   import usrt_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0] i_Paddr;
   logic              i_Psel;
   logic              i_Penable;
   logic              i_Pwrite;
   logic [DATA_W-1:0] i_Pwdata;
   logic [DATA_W-1:0] o_Prdata;
   logic              o_Pready;
   logic              o_Pslverr;

   modport master (
      output i_Paddr, i_Psel, i_Penable, i_Pwrite, i_Pwdata,
      input  o_Prdata, o_Pready, o_Pslverr
   );

   modport slave (
      input  i_Paddr, i_Psel, i_Penable, i_Pwrite, i_Pwdata,
      output o_Prdata, o_Pready, o_Pslverr
   );

endinterface

// File: rtl/apb_reg_port.sv
// APB3 slave front-end for the USRT register file: decodes N register slots,
// inserts wait states, flags illegal accesses and returns read data.
module apb_reg_port
   import usrt_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                SEL_LSB  = 30,
   parameter int                SEL_W    = 2,
   parameter int                N_REGS   = 3,
   parameter logic [N_REGS-1:0] WR_MASK  = N_REGS'(DEFAULT_WR_MASK),
   parameter logic [N_REGS-1:0] RD_MASK  = N_REGS'(DEFAULT_RD_MASK),
   parameter int                WAIT_CYC = 0
)(
   input  logic                     i_Pclk,
   input  logic                     i_Preset,
   apb_reg_port_if.slave            apb,
   output logic [N_REGS-1:0]        o_Wr_En,
   output logic [N_REGS-1:0]        o_Rd_En,
   output logic [DATA_W-1:0]        o_Wdata,
   input  logic [N_REGS*DATA_W-1:0] i_Rd_Data
);

   state_t            state;
   logic [3:0]        wait_cnt;
   logic [SEL_W-1:0]  idx_q;
   logic              wr_q;

   logic [N_REGS-1:0] sel_oh;
   logic              wr_ok;
   logic              rd_ok;
   logic              legal;
   logic [DATA_W-1:0] rd_word;

   // Only the select field of the address is decoded.
   logic unused_addr;
   assign unused_addr = ^apb.i_Paddr;

   // Decode the captured index; indices at or above N_REGS match no slot and
   // therefore come out illegal for both directions.
   always_comb begin
      sel_oh  = '0;
      wr_ok   = 1'b0;
      rd_ok   = 1'b0;
      rd_word = '0;
      for (int k = 0; k < N_REGS; k++) begin
         if (idx_q == SEL_W'(k)) begin
            sel_oh[k] = 1'b1;
            wr_ok     = WR_MASK[k];
            rd_ok     = RD_MASK[k];
            rd_word   = i_Rd_Data[k*DATA_W +: DATA_W];
         end
      end
      legal = wr_q ? wr_ok : rd_ok;
   end

   // Transfer FSM. Response outputs default low every cycle so that they
   // pulse for exactly the single RESP cycle; read data is registered at the
   // ACCESS->RESP edge, before the register sees the pop/clear strobe.
   always_ff @(posedge i_Pclk) begin
      if (i_Preset) begin
         state         <= S_IDLE;
         wait_cnt      <= 4'd0;
         idx_q         <= '0;
         wr_q          <= 1'b0;
         o_Wdata       <= '0;
         o_Wr_En       <= '0;
         o_Rd_En       <= '0;
         apb.o_Pready  <= 1'b0;
         apb.o_Pslverr <= 1'b0;
         apb.o_Prdata  <= '0;
      end else begin
         o_Wr_En       <= '0;
         o_Rd_En       <= '0;
         apb.o_Pready  <= 1'b0;
         apb.o_Pslverr <= 1'b0;
         apb.o_Prdata  <= '0;
         case (state)
            S_IDLE: begin
               if (apb.i_Psel && !apb.i_Penable) begin
                  idx_q    <= apb.i_Paddr[SEL_LSB +: SEL_W];
                  wr_q     <= apb.i_Pwrite;
                  o_Wdata  <= apb.i_Pwdata;
                  wait_cnt <= 4'(WAIT_CYC);
                  state    <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!apb.i_Psel) begin
                  state <= S_IDLE;
               end else if (apb.i_Penable) begin
                  if (wait_cnt == 4'd0) begin
                     state        <= S_RESP;
                     apb.o_Pready <= 1'b1;
                     if (!legal) begin
                        apb.o_Pslverr <= 1'b1;
                     end else if (wr_q) begin
                        o_Wr_En <= sel_oh;
                     end else begin
                        o_Rd_En      <= sel_oh;
                        apb.o_Prdata <= rd_word;
                     end
                  end else begin
                     wait_cnt <= wait_cnt - 4'd1;
                  end
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/apb_reg_port.md
# apb_reg_port

Parametrised APB3 slave front-end for the USRT register file. It replaces the fixed three-enable decoder with N register slots and a configurable decode field. It adds PREADY wait states, PSLVERR on illegal accesses, write-data forwarding and read-data return. It sits between the APB interconnect and the USRT status/TX/RX registers.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- SEL_LSB, 30, lowest address bit of the register-select field
- SEL_W, 2, width of the select field; N_REGS ≤ 2^SEL_W
- N_REGS, 3, number of register slots (0 = STATUS, 1 = TX, 2 = RX)
- WR_MASK, 3'b010, bit k set means slot k is writable
- RD_MASK, 3'b101, bit k set means slot k is readable
- WAIT_CYC, 0, extra wait states inserted before PREADY (0..15)

Ports:
- i_Pclk  in  1  APB clock, sole clock
- i_Preset  in  1  synchronous, active-high reset
- i_Paddr  in  ADDR_W  APB address
- i_Psel  in  1  APB select
- i_Penable  in  1  APB enable
- i_Pwrite  in  1  1 = write
- i_Pwdata  in  DATA_W  write data
- o_Prdata  out  DATA_W  read data, valid while o_Pready=1
- o_Pready  out  1  transfer-complete, one-cycle pulse
- o_Pslverr  out  1  error response, valid only with o_Pready
- o_Wr_En  out  N_REGS  one-hot write strobe
- o_Rd_En  out  N_REGS  one-hot read strobe (side-effect pop/clear)
- o_Wdata  out  DATA_W  captured write data, stable from ACCESS through RESP
- i_Rd_Data  in  N_REGS*DATA_W  concatenated register contents; slot k is bits [k*DATA_W +: DATA_W]

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE: on i_Psel=1 and i_Penable=0, capture idx=i_Paddr[SEL_LSB +: SEL_W], i_Pwrite and i_Pwdata. Load wait counter with WAIT_CYC. Go to ACCESS.
- IDLE with i_Psel=1 and i_Penable=1 is a protocol violation: ignored, stay in IDLE.
- ACCESS: the counter decrements only while i_Psel=1 and i_Penable=1.
  - When the counter is 0 and i_Penable=1, evaluate legality and go to RESP.
  - Legal write: idx < N_REGS and WR_MASK[idx]=1.
  - Legal read: idx < N_REGS and RD_MASK[idx]=1.
- ACCESS with i_Psel=0 is an abort: return to IDLE with no strobe and no o_Pready.
- RESP lasts exactly 1 cycle: o_Pready=1.
  - Legal write: o_Wr_En[idx]=1.
  - Legal read: o_Rd_En[idx]=1, and o_Prdata holds i_Rd_Data slot idx as sampled at the ACCESS→RESP edge, i.e. before any read side effect.
  - Illegal access: o_Pslverr=1, o_Prdata=0, no strobe.
  - Then go to IDLE unconditionally.
- Address, data or direction changes after the setup phase are ignored; the captured values are used.
- At most one strobe bit is ever high. Strobes and o_Pslverr are high only in RESP.

## Timing
- Reset (synchronous, any state): state=IDLE, counter=0; o_Pready, o_Pslverr, o_Wr_En, o_Rd_En, o_Prdata, o_Wdata all 0.
  - A transfer in flight at reset is dropped with no strobe.
- Latency with WAIT_CYC=0:
  - cycle 0: setup phase;
  - cycle 1: enable phase, o_Pready=0 (one inherent wait state);
  - cycle 2: o_Pready=1 and strobe.
- Each WAIT_CYC adds one enable cycle before RESP.
- Back-to-back transfers: a setup phase in the cycle after RESP is accepted, giving 3 cycles per transfer minimum.
- The strobe is coincident with o_Pready. The register acts on the clock edge that ends RESP.

## Structure
- Shared usrt_pkg holds:
  - state encodings S_IDLE=2'd0, S_ACCESS=2'd1, S_RESP=2'd2;
  - slot indices REG_STATUS=0, REG_TX=1, REG_RX=2;
  - default WR_MASK and RD_MASK values.
- No sub-module. The decode, wait counter and read mux are small enough to stay inline.

## Test plan
- Write 0x4000_0000, data 0xA5, WAIT_CYC=0 -> o_Pready in cycle 2; o_Wr_En=3'b010 for 1 cycle; o_Wdata=0xA5; o_Pslverr=0.
- Read 0x8000_0000 with slot 2=0x5A and WAIT_CYC=3 -> o_Pready in cycle 5; o_Prdata=0x5A; o_Rd_En=3'b100 for 1 cycle.
- Illegal accesses -> each gives o_Pslverr=1 with o_Pready, no strobe, o_Prdata=0:
  - write 0x0000_0000 (STATUS is read-only);
  - read 0x4000_0000 (TX is write-only);
  - any access to 0xC000_0000 (unmapped idx 3).
- Abort: i_Psel dropped in cycle 1 -> no o_Pready, no strobe; the next transfer completes normally.
- i_Preset asserted during ACCESS with WAIT_CYC=2 -> all outputs 0 on the next cycle, no strobe ever issued.
- Back-to-back: write TX then read STATUS with no idle cycle -> two o_Pready pulses 3 cycles apart, each with the correct single strobe.
